// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller slice.
//   rx_state_t   : controller FSM states (OFF/IDLE/FRAME/HOLD)
//   BYTE_W       : received byte width
//   DEPTH_DEF    : default receive FIFO depth (power of 2)
//   FRAME_TO_DEF : default cycles allowed from start bit to receiver done
//   sat_inc8     : saturating 8-bit increment
package uart_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned DEPTH_DEF    = 4;
  localparam int unsigned FRAME_TO_DEF = 12;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FRAME = 2'd2,
    ST_HOLD  = 2'd3
  } rx_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Host read handshake of the UART receive controller (FWFT FIFO head).
//   rd_valid_o : byte available
//   rd_data_o  : FIFO head byte
//   rd_ready_i : host pop (effective when rd_valid_o is also high)
// master = controller side, slave = host side.
interface uart_rx_ctrl_if;
  import uart_pkg::*;

  logic              rd_valid_o;
  logic [BYTE_W-1:0] rd_data_o;
  logic              rd_ready_i;

  modport master (output rd_valid_o, output rd_data_o, input rd_ready_i);
  modport slave  (input rd_valid_o, input rd_data_o, output rd_ready_i);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes.
//   clk, rst_n : clock, synchronous active-low reset (clears contents)
//   i_push     : write request; accepted when not full, or full with a pop
//   i_data     : write byte
//   i_pop      : read request; ignored when empty
//   o_data     : head byte (valid when !o_empty)
//   o_full     : count == DEPTH
//   o_empty    : count == 0
//   o_count    : occupancy 0..DEPTH
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [CW-1:0]     o_count
);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_wr;
  logic              w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_rd = i_pop && !o_empty;
  // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: tracks frames from start bit to receiver done,
// captures the byte into a FWFT FIFO, times out stalled frames and keeps
// sticky overflow / saturating frame-error status.
//   clk, rst_n  : clock, synchronous active-low reset
//   rx_line_i   : serial line monitor (0 = start bit)
//   rx_done_i   : receiver done
//   rx_data_i   : receiver byte, meaningful only in the done cycle
//   rx_en_o     : receiver enable (registered, 0 only in OFF)
//   ctrl_en_i   : reception enable
//   clr_i       : clear ovf_o and err_cnt_o (wins over a coincident event)
//   rd_if       : host read handshake (master side)
//   fifo_cnt_o  : FIFO occupancy
//   ovf_o       : sticky overflow
//   err_cnt_o   : frame-error count, saturates at 255
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH    = DEPTH_DEF,
  parameter  int unsigned FRAME_TO = FRAME_TO_DEF,
  localparam int unsigned CW       = $clog2(DEPTH) + 1,
  localparam int unsigned FW       = $clog2(FRAME_TO) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_line_i,
  input  logic              rx_done_i,
  input  logic [BYTE_W-1:0] rx_data_i,
  output logic              rx_en_o,
  input  logic              ctrl_en_i,
  input  logic              clr_i,
  uart_rx_ctrl_if.master    rd_if,
  output logic [CW-1:0]     fifo_cnt_o,
  output logic              ovf_o,
  output logic [7:0]        err_cnt_o
);

  rx_state_t     r_state;
  logic          r_rx_en;
  logic [FW-1:0] r_frm_cnt;
  logic          r_ovf;
  logic [7:0]    r_err_cnt;

  logic          w_capture;
  logic          w_timeout;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;

  assign w_capture = (r_state == ST_FRAME) && rx_done_i;
  assign w_timeout = (r_state == ST_FRAME) && !rx_done_i &&
                     (r_frm_cnt == FW'(FRAME_TO - 1));
  assign w_pop     = !w_empty && rd_if.rd_ready_i;

  // rx_data_i reaches the FIFO write port only through the capture qualifier.
  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_capture),
    .i_data  (rx_data_i),
    .i_pop   (w_pop),
    .o_data  (rd_if.rd_data_o),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_cnt_o)
  );

  assign rd_if.rd_valid_o = !w_empty;
  assign rx_en_o          = r_rx_en;
  assign ovf_o            = r_ovf;
  assign err_cnt_o        = r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_OFF;
      r_rx_en   <= 1'b0;
      r_frm_cnt <= '0;
      r_ovf     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (ctrl_en_i) begin
            r_state <= ST_IDLE;
            r_rx_en <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (!ctrl_en_i) begin
            r_state <= ST_OFF;
            r_rx_en <= 1'b0;
          end else if (!rx_line_i) begin
            r_state   <= ST_FRAME;
            r_frm_cnt <= '0;
          end
        end
        // ctrl_en_i is deliberately ignored here so a frame in flight completes.
        ST_FRAME: begin
          if (rx_done_i) begin
            r_state <= ST_HOLD;
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
          end else begin
            r_frm_cnt <= r_frm_cnt + FW'(1);
          end
        end
        ST_HOLD: begin
          if (!rx_done_i) begin
            r_state <= ctrl_en_i ? ST_IDLE : ST_OFF;
            r_rx_en <= ctrl_en_i;
          end
        end
        default: begin
          r_state <= ST_OFF;
          r_rx_en <= 1'b0;
        end
      endcase

      if (clr_i) begin
        r_ovf     <= 1'b0;
        r_err_cnt <= '0;
      end else begin
        if (w_capture && w_full && !w_pop) r_ovf <= 1'b1;
        if (w_timeout) r_err_cnt <= sat_inc8(r_err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a byte scoreboard.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned FRAME_TO = 12;
  localparam int unsigned NONE     = 32'hFFFF_FFFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en;
  logic       ctrl_en = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] fifo_cnt;
  logic       ovf;
  logic [7:0] err_cnt;

  uart_rx_ctrl_if rd_if();

  uart_rx_ctrl #(.DEPTH(DEPTH), .FRAME_TO(FRAME_TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_line_i  (rx_line),
    .rx_done_i  (rx_done),
    .rx_data_i  (rx_data),
    .rx_en_o    (rx_en),
    .ctrl_en_i  (ctrl_en),
    .clr_i      (clr),
    .rd_if      (rd_if),
    .fifo_cnt_o (fifo_cnt),
    .ovf_o      (ovf),
    .err_cnt_o  (err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  exp_q[$];
  bit          m_ovf = 1'b0;
  int unsigned m_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_cnt"}, 32'(fifo_cnt), 32'(exp_q.size()));
    check_eq({tag, "_valid"}, 32'(rd_if.rd_valid_o), 32'(exp_q.size() != 0));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
    check_eq({tag, "_err"}, 32'(err_cnt), m_err);
    if (exp_q.size() != 0) check_eq({tag, "_head"}, 32'(rd_if.rd_data_o), 32'(exp_q[0]));
  endtask

  task automatic pop_one(input string tag, output logic [7:0] got);
    logic [7:0] e;
    check_eq({tag, "_pvalid"}, 32'(rd_if.rd_valid_o), 32'd1);
    e   = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    got = rd_if.rd_data_o;
    check_eq({tag, "_pdata"}, 32'(got), 32'(e));
    rd_if.rd_ready_i = 1'b1;
    step();
    rd_if.rd_ready_i = 1'b0;
  endtask

  // Start bit, done_at cycles of frame, one capture cycle, hold_cyc extra
  // cycles with done high (line held low to probe start-bit masking in HOLD).
  task automatic send_frame(input logic [7:0] d, input int unsigned done_at,
                            input bit pop_cap, input int unsigned hold_cyc,
                            input int unsigned drop_en_at);
    logic [7:0] pe;
    rx_line = 1'b0;
    step();
    rx_line = 1'b1;
    for (int unsigned k = 0; k < done_at; k++) begin
      if (k == drop_en_at) ctrl_en = 1'b0;
      rx_data = 8'($urandom);
      step();
    end
    rx_done = 1'b1;
    rx_data = d;
    if (pop_cap) begin
      pe = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      check_eq("cap_pop_data", 32'(rd_if.rd_data_o), 32'(pe));
      rd_if.rd_ready_i = 1'b1;
    end
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else m_ovf = 1'b1;
    step();
    rd_if.rd_ready_i = 1'b0;
    rx_data = 8'($urandom);
    check_eq("cap_latency_valid", 32'(rd_if.rd_valid_o), 32'd1);
    rx_line = 1'b0;
    for (int unsigned k = 0; k < hold_cyc; k++) begin
      check_eq("hold_rx_en", 32'(rx_en), 32'd1);
      step();
    end
    rx_done = 1'b0;
    rx_line = 1'b1;
    step();
    check_eq("post_hold_rx_en", 32'(rx_en), 32'(ctrl_en));
  endtask

  task automatic timeout_frame(input bit clr_at_to);
    rx_line = 1'b0;
    step();
    rx_line = 1'b1;
    repeat (FRAME_TO - 1) step();
    check_eq("pre_timeout_err", 32'(err_cnt), m_err);
    if (clr_at_to) begin
      clr = 1'b1;
      m_err = 0;
      m_ovf = 1'b0;
    end else if (m_err < 255) begin
      m_err++;
    end
    step();
    clr = 1'b0;
  endtask

  logic [7:0] got;

  initial begin
    rd_if.rd_ready_i = 1'b0;
    step();
    step();
    check_eq("rst_rx_en", 32'(rx_en), 32'd0);
    check_eq("rst_rd_data", 32'(rd_if.rd_data_o), 32'h00);
    check_status("rst");
    rst_n = 1'b1;
    ctrl_en = 1'b1;
    step();
    check_eq("en_rx_en", 32'(rx_en), 32'd1);

    // Test 1: byte captured at frm_cnt=9
    send_frame(8'hA5, 9, 1'b0, 1, NONE);
    check_status("t1");
    check_eq("t1_byte", 32'(rd_if.rd_data_o), 32'hA5);
    pop_one("t1", got);

    // Test 2: timeout
    timeout_frame(1'b0);
    check_status("t2");
    check_eq("t2_rx_en", 32'(rx_en), 32'd1);

    // Test 3: overflow
    for (int unsigned i = 1; i <= 5; i++) send_frame(8'(i), 3, 1'b0, 0, NONE);
    check_status("t3");
    check_eq("t3_ovf", 32'(ovf), 32'd1);
    for (int unsigned i = 0; i < 4; i++) pop_one("t3", got);
    check_status("t3_drained");

    // Test 4: push while full with coincident pop
    clr = 1'b1;
    m_ovf = 1'b0;
    m_err = 0;
    step();
    clr = 1'b0;
    check_status("t4_clr");
    for (int unsigned i = 1; i <= 4; i++) send_frame(8'(i), 4, 1'b0, 0, NONE);
    send_frame(8'h05, 4, 1'b1, 0, NONE);
    check_status("t4");
    for (int unsigned i = 0; i < 4; i++) pop_one("t4", got);
    check_eq("t4_last", 32'(got), 32'h05);

    // Test 5: enable dropped mid-frame
    send_frame(8'h5A, 6, 1'b0, 2, 3);
    check_eq("t5_rx_en_off", 32'(rx_en), 32'd0);
    check_status("t5");
    pop_one("t5", got);
    ctrl_en = 1'b1;
    step();
    check_eq("t5_reen", 32'(rx_en), 32'd1);

    // Test 6: reset mid-frame with bytes queued
    send_frame(8'h11, 2, 1'b0, 0, NONE);
    send_frame(8'h22, 5, 1'b0, 0, NONE);
    timeout_frame(1'b0);
    rx_line = 1'b0;
    step();
    rx_line = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    ctrl_en = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    m_ovf = 1'b0;
    m_err = 0;
    check_eq("t6_rx_en", 32'(rx_en), 32'd0);
    check_eq("t6_rd_data", 32'(rd_if.rd_data_o), 32'h00);
    check_status("t6");
    ctrl_en = 1'b1;
    step();
    send_frame(8'h33, 7, 1'b0, 0, NONE);
    check_status("t6_after");
    pop_one("t6", got);

    // Error counter saturation, then clear coinciding with a timeout
    for (int unsigned i = 0; i < 257; i++) timeout_frame(1'b0);
    check_eq("sat_err", 32'(err_cnt), 32'd255);
    timeout_frame(1'b1);
    check_status("clr_sat");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, receive FIFO entries (power of 2); FRAME_TO, default 12, cycles allowed from start bit to receiver done.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 system clock; rst_n in 1 reset, synchronous, active-low.
REQ-003 Receiver-side ports SHALL be: rx_line_i in 1 serial line monitor; rx_done_i in 1 receiver done; rx_data_i in 8 receiver byte bus, tri-stated except in the done cycle; rx_en_o out 1 receiver enable.
REQ-004 Host-side ports SHALL be: ctrl_en_i in 1 reception enable; clr_i in 1 clear of sticky flags and counters; rd_valid_o out 1 byte available; rd_data_o out 8 FIFO head byte; rd_ready_i in 1 host pop.
REQ-005 Status ports SHALL be: fifo_cnt_o out $clog2(DEPTH)+1 occupancy; ovf_o out 1 sticky overflow; err_cnt_o out 8 frame-error count.

Function
REQ-006 The FSM SHALL have states OFF, IDLE, FRAME, HOLD; rx_en_o SHALL be 1 in IDLE, FRAME and HOLD, and 0 in OFF.
REQ-007 OFF->IDLE SHALL occur when ctrl_en_i=1; IDLE->OFF SHALL occur when ctrl_en_i=0.
REQ-008 IDLE->FRAME SHALL occur on rx_line_i=0 (start bit), loading frame counter frm_cnt=0.
REQ-009 In FRAME, frm_cnt SHALL increment every cycle.
REQ-010 In FRAME, when rx_done_i=1, the block SHALL sample rx_data_i in that same cycle, push it to the FIFO, and go to HOLD.
REQ-011 In FRAME, when frm_cnt reaches FRAME_TO-1 with rx_done_i=0 (parity or framing failure), err_cnt_o SHALL increment, saturating at 255, and the FSM SHALL go to IDLE.
REQ-012 HOLD SHALL wait for rx_done_i=0, then go to IDLE if ctrl_en_i=1, else OFF; a new start bit SHALL NOT be recognised in HOLD.
REQ-013 ctrl_en_i deasserting in FRAME SHALL NOT abort the frame; the transition to OFF SHALL occur after HOLD or timeout.
REQ-014 rx_data_i SHALL be sampled only in the REQ-010 capture cycle, never otherwise.
REQ-015 The FIFO SHALL be synchronous first-word-fall-through: rd_valid_o=(count!=0); rd_data_o=head; a pop SHALL occur when rd_valid_o and rd_ready_i are both 1.
REQ-016 A push while full with no pop SHALL drop the byte and set ovf_o; a push and pop in the same cycle while full SHALL both be accepted, keeping the count unchanged.
REQ-017 A push and pop in the same cycle while empty SHALL be impossible, because FWFT pop requires valid; the push SHALL apply normally.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH; fifo_cnt_o SHALL range 0..DEPTH.
REQ-019 clr_i SHALL clear ovf_o and err_cnt_o next cycle; an event coinciding with clr_i SHALL be lost, with clear taking priority; FIFO contents SHALL be unaffected.
REQ-020 Capture-to-rd_valid_o latency SHALL be 1 cycle.

Reset
REQ-021 With rst_n=0 at a clk rising edge, the block SHALL enter state OFF with rx_en_o=0, FIFO empty, rd_valid_o=0, fifo_cnt_o=0, ovf_o=0, err_cnt_o=0, frm_cnt=0.
REQ-022 rd_data_o SHALL be 8'h00 after reset.
REQ-023 Reset mid-frame SHALL discard the partial frame and all FIFO contents.

Structure
REQ-024 A shared package uart_pkg SHALL hold the FSM state encoding (OFF/IDLE/FRAME/HOLD), the byte width 8, and the FRAME_TO and DEPTH defaults.
REQ-025 The FIFO SHALL be a sub-module uart_rx_fifo (DEPTH, 8-bit, FWFT, push/pop/full/empty/count); the FSM and counters SHALL reside in uart_rx_ctrl.

Verification
REQ-026 Test 1: ctrl_en_i=1, line low, then rx_done_i=1 with rx_data_i=8'hA5 at frm_cnt=9 -> rd_valid_o=1 next cycle, rd_data_o=8'hA5, fifo_cnt_o=1.
REQ-027 Test 2: start bit with no rx_done_i within 12 cycles -> err_cnt_o=1, FSM in IDLE, FIFO unchanged.
REQ-028 Test 3: 5 frames 8'h01..8'h05 with rd_ready_i=0 -> fifo_cnt_o=4, ovf_o=1, pops return 01,02,03,04.
REQ-029 Test 4: FIFO full, 5th frame captured in the same cycle as a pop -> no overflow, count stays 4, last pop returns 8'h05.
REQ-030 Test 5: ctrl_en_i dropped mid-frame -> byte still captured, rx_en_o=0 after rx_done_i falls.
REQ-031 Test 6: rst_n=0 mid-frame with 2 bytes queued -> all outputs at REQ-021 values next cycle; clr_i with err_cnt_o=255 -> 0.
